// File: rtl/booth_mul_sched_pkg.sv
// Shared types, default widths and width helpers for the Booth multiplier
// scheduler and its arbiter.
package booth_sched_pkg;

  localparam int N_DEF    = 4;
  localparam int NREQ_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_sched_if.sv
// Requester-side request/response bundle of the shared multiplier scheduler.
interface booth_mul_sched_if
  import booth_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_mr;
  logic [NREQ*N-1:0] req_md;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [2*N-1:0]    resp_prod;

  modport master (
    output req_valid, req_mr, req_md, resp_ready,
    input  req_ready, resp_valid, resp_prod
  );

  modport slave (
    input  req_valid, req_mr, req_md, resp_ready,
    output req_ready, resp_valid, resp_prod
  );
endinterface

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after last_grant has the
// highest priority; the pointer register is held by the caller.
module rr_arbiter
  import booth_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found_s;

  // Scan indices above the pointer first, then wrap to the lower ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i] && (IW'(i) > last_grant)) begin
        found_s   = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i] && (IW'(i) <= last_grant)) begin
        found_s   = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/booths_algo.sv
// Radix-2 Booth multiplier: loads operands while rst is high, then performs
// one add/shift step per cycle and holds the product after N steps.
module booths_algo
  import booth_sched_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int CW = cnt_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   mr_in,
  input  logic [N-1:0]   md,
  output logic [2*N-1:0] out
);

  // Accumulator and multiplicand carry a guard bit so -(-2^(N-1)) is exact.
  logic [N:0]    a_r;
  logic [N:0]    m_r;
  logic [N-1:0]  q_r;
  logic          q1_r;
  logic [CW-1:0] step_r;
  logic [N:0]    sum_s;

  // Booth recoding of the current multiplier bit pair.
  always_comb begin
    case ({q_r[0], q1_r})
      2'b01:   sum_s = a_r + m_r;
      2'b10:   sum_s = a_r - m_r;
      default: sum_s = a_r;
    endcase
  end

  // Operand load and arithmetic right shift of {A, Q, q-1}.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      m_r    <= {md[N-1], md};
      q_r    <= mr_in;
      q1_r   <= 1'b0;
      step_r <= '0;
    end else if (step_r != CW'(N)) begin
      a_r    <= {sum_s[N], sum_s[N:1]};
      q_r    <= {sum_s[0], q_r[N-1:1]};
      q1_r   <= q_r[0];
      step_r <= step_r + CW'(1);
    end
  end

  assign out = {a_r[N-1:0], q_r};

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one multi-cycle Booth multiplier between
// NREQ requesters; returns each product to the requester that issued it.
module booth_mul_sched
  import booth_sched_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int CW   = cnt_width(N),
  localparam int IW   = idx_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  booth_mul_sched_if.slave    bus,
  output logic                busy,
  output logic                mul_rst,
  output logic [N-1:0]        mul_mr,
  output logic [N-1:0]        mul_md,
  input  logic [2*N-1:0]      mul_out
);

  sched_state_t    state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   owner_r, last_grant_r;
  logic [NREQ-1:0] resp_valid_r;
  logic [2*N-1:0]  resp_prod_r;
  logic [N-1:0]    mul_mr_r, mul_md_r;
  logic [NREQ-1:0] grant_s, req_ready_s, own_onehot_s;
  logic [IW-1:0]   grant_idx_s;
  logic [N-1:0]    sel_mr_s, sel_md_s;
  logic            release_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // Winner operand mux and owner decode; grant is one-hot so OR-merging is safe.
  always_comb begin
    sel_mr_s     = '0;
    sel_md_s     = '0;
    own_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_mr_s        = sel_mr_s | (bus.req_mr[i*N +: N] & {N{grant_s[i]}});
      sel_md_s        = sel_md_s | (bus.req_md[i*N +: N] & {N{grant_s[i]}});
      own_onehot_s[i] = (owner_r == IW'(i));
    end
    release_s = |(bus.resp_ready & own_onehot_s);
  end

  // Next-state and accept logic.
  always_comb begin
    state_s     = state_r;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        req_ready_s = grant_s;
        if (|grant_s) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: state_s = ITER;
      ITER: begin
        if (cnt_r == '0) state_s = DONE;
        else             state_s = ITER;
      end
      DONE: begin
        if (release_s) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand, ownership, iteration count and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      owner_r      <= '0;
      last_grant_r <= IW'(NREQ - 1);
      resp_valid_r <= '0;
      resp_prod_r  <= '0;
      mul_mr_r     <= '0;
      mul_md_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            mul_mr_r     <= sel_mr_s;
            mul_md_r     <= sel_md_s;
            owner_r      <= grant_idx_s;
            last_grant_r <= grant_idx_s;
          end
        end
        LOAD: cnt_r <= CW'(N);
        ITER: begin
          if (cnt_r == '0) begin
            resp_prod_r  <= mul_out;
            resp_valid_r <= own_onehot_s;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE: begin
          if (release_s) resp_valid_r <= '0;
        end
        default: resp_valid_r <= '0;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_prod  = resp_prod_r;
  assign busy           = (state_r != IDLE);
  assign mul_rst        = rst | (state_r == LOAD);
  assign mul_mr         = mul_mr_r;
  assign mul_md         = mul_md_r;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed self-checking bench for booth_mul_sched with one booths_algo.
module tb_booth_mul_sched;
  import booth_sched_pkg::*;

  localparam int N    = 4;
  localparam int NREQ = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy, mul_rst;
  logic [N-1:0]   mul_mr, mul_md;
  logic [2*N-1:0] mul_out;

  int n_checks = 0;
  int n_fail   = 0;
  int seen;

  logic [N-1:0]   op_mr   [NREQ];
  logic [N-1:0]   op_md   [NREQ];
  logic [2*N-1:0] op_prod [NREQ];

  booth_mul_sched_if #(.N(N), .NREQ(NREQ)) bus ();

  booth_mul_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .mul_rst (mul_rst),
    .mul_mr  (mul_mr),
    .mul_md  (mul_md),
    .mul_out (mul_out)
  );

  booths_algo #(.N(N)) u_mul (
    .clk   (clk),
    .rst   (mul_rst),
    .mr_in (mul_mr),
    .md    (mul_md),
    .out   (mul_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i);
    bus.req_mr[i*N +: N] = op_mr[i];
    bus.req_md[i*N +: N] = op_md[i];
    bus.req_valid[i]     = 1'b1;
  endtask

  // Expects requester w to win in IDLE; returns at the negedge after accept.
  task automatic start(input int w);
    #1;
    check("req_ready grant", 32'(bus.req_ready), 32'(1 << w));
    @(negedge clk);
    bus.req_valid[w] = 1'b0;
    check("busy after accept", 32'(busy), 32'd1);
    check("req_ready in LOAD", 32'(bus.req_ready), 32'd0);
    check("mul_mr latched", 32'(mul_mr), 32'(op_mr[w]));
    check("mul_md latched", 32'(mul_md), 32'(op_md[w]));
  endtask

  task automatic wait_valid(input int w);
    int lat;
    lat = 0;
    while (bus.resp_valid == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
      check("mul_mr stable", 32'(mul_mr), 32'(op_mr[w]));
      check("mul_md stable", 32'(mul_md), 32'(op_md[w]));
    end
    check("latency", 32'(lat), 32'(N + 2));
    check("resp_valid owner", 32'(bus.resp_valid), 32'(1 << w));
    check("resp_prod", 32'(bus.resp_prod), 32'(op_prod[w]));
  endtask

  task automatic release_resp(input int w);
    bus.resp_ready[w] = 1'b1;
    @(negedge clk);
    bus.resp_ready[w] = 1'b0;
    check("resp_valid cleared", 32'(bus.resp_valid), 32'd0);
    check("busy idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_mr     = '0;
    bus.req_md     = '0;
    bus.resp_ready = '0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_prod", 32'(bus.resp_prod), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mul_mr", 32'(mul_mr), 32'd0);
    check("rst mul_md", 32'(mul_md), 32'd0);
    check("rst mul_rst", 32'(mul_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mul_rst idle", 32'(mul_rst), 32'd0);

    // 7 x 5 from requester 0, then 3 x -5 from requester 1
    op_mr[0] = 4'd7; op_md[0] = 4'd5;    op_prod[0] = 8'h23;
    op_mr[1] = 4'd3; op_md[1] = 4'b1011; op_prod[1] = 8'hF1;
    raise(0); start(0); wait_valid(0); release_resp(0);
    raise(1); start(1); wait_valid(1); release_resp(1);

    // both always requesting: grants alternate starting with requester 0
    for (int p = 0; p < 8; p++) begin
      raise(0);
      raise(1);
      start(p % 2);
      wait_valid(p % 2);
      release_resp(p % 2);
    end
    bus.req_valid = '0;

    // most-negative corners
    op_mr[0] = 4'h8; op_md[0] = 4'h8; op_prod[0] = 8'h40;
    raise(0); start(0); wait_valid(0); release_resp(0);
    op_mr[0] = 4'h8; op_md[0] = 4'h7; op_prod[0] = 8'hC8;
    raise(0); start(0); wait_valid(0); release_resp(0);

    // response stall: DONE held, non-owner resp_ready ignored, req1 waits
    op_mr[0] = 4'd7; op_md[0] = 4'd5; op_prod[0] = 8'h23;
    raise(0); start(0); wait_valid(0);
    raise(1);
    bus.resp_ready[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall resp_valid", 32'(bus.resp_valid), 32'd1);
      check("stall resp_prod", 32'(bus.resp_prod), 32'h23);
      check("stall busy", 32'(busy), 32'd1);
      check("stall req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready[1] = 1'b0;
    release_resp(0);
    start(1); wait_valid(1); release_resp(1);

    // reset during the third ITER cycle aborts the operation
    raise(0); start(0);
    repeat (3) @(negedge clk);
    check("busy in ITER", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mul_rst follows rst", 32'(mul_rst), 32'd1);
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort resp_prod", 32'(bus.resp_prod), 32'd0);
    check("abort req_ready", 32'(bus.req_ready), 32'd0);
    check("abort mul_mr", 32'(mul_mr), 32'd0);
    check("abort mul_md", 32'(mul_md), 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen = 1;
    end
    check("no resp after abort", 32'(seen), 32'd0);

    // pointer back at reset value: requester 0 wins, then requester 1 is offered
    raise(0); raise(1); start(0); wait_valid(0); release_resp(0);
    check("rr after reset", 32'(bus.req_ready), 32'd2);
    bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Sequencing controller and round-robin arbiter that shares one multi-cycle Booth multiplier (`booths_algo`) between `NREQ` requesters. It accepts signed operand pairs over valid/ready, loads them into the multiplier by pulsing the multiplier's reset, and counts out the iteration cycles. It then captures the `2N`-bit signed product and returns it to the issuing requester over a held response handshake. It sits between the requester-side logic and the single multiplier instance.

## Interface
- `N`, 4: operand width; passed to the multiplier.
- `NREQ`, 2: number of requesters, ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot accept; the handshake completes on `req_valid[i] & req_ready[i]`.
- `req_mr`  in  NREQ*N  multipliers, requester i at bits [i*N +: N], signed.
- `req_md`  in  NREQ*N  multiplicands, same packing, signed.
- `resp_valid`  out  NREQ  one-hot response valid.
- `resp_ready`  in  NREQ  per-requester response accept.
- `resp_prod`  out  2N  shared signed product bus, valid where `resp_valid` is set.
- `busy`  out  1  high whenever state ≠ IDLE.
- `mul_rst`  out  1  drives multiplier `rst`; `rst | (state==LOAD)`.
- `mul_mr`, `mul_md`  out  N  drive multiplier `mr_in` and `md`.
- `mul_out`  in  2N  multiplier `out`.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE.
- **IDLE**
  - The round-robin arbiter picks one requester with `req_valid`, starting from the requester after `last_grant`.
  - `req_ready` is high only for that winner. It is combinational from state and `req_valid`, and is zero outside IDLE.
  - On the accept edge: latch `mr`/`md` into `mul_mr`/`mul_md`, latch the owner id, set `last_grant` = owner, then go to LOAD.
- **LOAD**
  - One cycle with `mul_rst`=1; the multiplier loads operands.
  - Go to ITER with the iteration counter set to N.
- **ITER**
  - Lasts N+1 cycles; the counter decrements each cycle.
  - On the edge where the counter is 0: `resp_prod` ← `mul_out`, then go to DONE.
- **DONE**
  - `resp_valid[owner]`=1, and `resp_prod` is held.
  - On `resp_ready[owner]`: clear `resp_valid`, then go to IDLE.
  - `resp_ready` from non-owners is ignored.
- `mul_mr`/`mul_md` are held stable from accept until the next accept.
- Arithmetic: two's-complement; the product is the full 2N bits and cannot overflow. The most-negative × most-negative case is exact (N=4: −8×−8=64).
- Requester obligation: keep `req_valid` and operands stable until accepted. Dropping `req_valid` before grant is legal; the request is simply not taken.

## Timing
- Reset values:
  - state IDLE; `req_ready` 0; `resp_valid` 0; `resp_prod` 0; `busy` 0.
  - `mul_mr`/`mul_md` 0; `mul_rst` 1 while `rst` is high.
  - `last_grant` = NREQ−1, so requester 0 has first priority.
- Latency: accept edge E0 → LOAD cycle → N+1 ITER cycles → `resp_valid` rises after edge E0+N+2 (N=4: 6 cycles).
- Occupancy: N+3 cycles plus response wait; the minimum issue-to-issue interval is N+4 cycles, with `resp_ready` already high.
- Simultaneous requests: exactly one grant per IDLE visit; round-robin guarantees each waiting requester service within NREQ operations.
- A response stall (`resp_ready` low) holds DONE indefinitely. No new request is accepted, and the product stays stable.
- New request from the current owner while in DONE: not accepted before IDLE, and the pointer has rotated past it.
- `rst` mid-operation (any state):
  - The next cycle is IDLE and the operation is aborted; no response is issued.
  - The multiplier is reset through `mul_rst`.
  - The pointer returns to its reset value.

## Structure
- Package `booth_sched_pkg`:
  - state enum `sched_state_t` (IDLE/LOAD/ITER/DONE);
  - default widths `N_DEF`=4 and `NREQ_DEF`=2;
  - counter width `$clog2(N+2)`.
- Sub-module `rr_arbiter` (NREQ-wide): inputs `req`, `last_grant`; outputs one-hot `grant` and its index. It is purely combinational; the pointer register lives in `booth_mul_sched`.
- The bench instantiates `booth_mul_sched` with one `booths_algo #(N)`.

## Test plan
- Single request from requester 0: mr=7, md=5 → `req_ready[0]` in the same cycle; `resp_valid[0]` 6 cycles later; `resp_prod`=35 (8'h23).
- Requester 1: mr=3, md=−5 (4'b1011) → `resp_prod`=−15 (8'hF1) on `resp_valid[1]` only.
- Both valid at once: req0 (7,5) and req1 (3,−5) → req0 granted first (35), then req1 (−15); grant order alternates over 4 repeated pairs.
- Corner operands −8×−8 and −8×7 → 64 and −56; `mul_mr`/`mul_md` stay stable through ITER.
- Hold `resp_ready[0]` low for 10 cycles → `resp_valid[0]` and `resp_prod` held, `busy`=1, `req_ready` all 0, and req1 is not accepted until release.
- Assert `rst` during the 3rd ITER cycle → IDLE the next cycle, all outputs at reset values, no `resp_valid`; a subsequent 7×5 still returns 35.
